register_stream_writer: RTL and testbench

Write side of the datapath register stream: captures the shared 32-bit bus into any subset of the 25 datapath registers, selected by a per-register load-enable vector.
Drives the packed registerStream that the bus select mux reads, so its index ordering matches the mux exactly.

---
 rtl/register_stream_writer_pkg.sv | 25 ++
 rtl/register_stream_writer_load_register.sv | 27 ++
 rtl/register_stream_writer.sv | 115 +++++++++++
 tb/tb_register_stream_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_stream_writer_pkg.sv
// Shared index map and sizes for the datapath register stream.
// Also imported by the bus select mux, so the index ordering lives here.
package register_stream_writer_pkg;

    localparam int WORD_BITS = 32;
    localparam int NUM_REGS  = 25;

    localparam int R0_IDX  = 0;
    localparam int PC_IDX  = 16;
    localparam int IR_IDX  = 17;
    localparam int RY_IDX  = 18;
    localparam int ZLO_IDX = 19;
    localparam int ZHI_IDX = 20;
    localparam int MAR_IDX = 21;
    localparam int HI_IDX  = 22;
    localparam int LO_IDX  = 23;
    localparam int MDR_IDX = 24;

    // Registers with no special load path: plain bus capture.
    function automatic bit is_general(input int idx);
        return !(idx == PC_IDX || idx == ZLO_IDX ||
                 idx == ZHI_IDX || idx == MDR_IDX);
    endfunction

endpackage

// File: rtl/register_stream_writer_load_register.sv
// BITS-wide register with load enable and synchronous active-low clear.
module register_stream_writer_load_register #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    logic [BITS-1:0] q_q;
    logic [BITS-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (!clr) q_q <= '0;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/register_stream_writer.sv
// Write side of the datapath register stream: bus capture, Z/MDR/PC paths.
// Build option R0_ZERO_EN hardwires r0 to zero.
module register_stream_writer
    import register_stream_writer_pkg::*;
#(
    parameter int BITS       = WORD_BITS,
    parameter int REGISTERS  = NUM_REGS,
    parameter int COUNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [BITS-1:0]           busMuxIn,
    input  logic [REGISTERS-1:0]      registerLoad,
    input  logic                      zLoad,
    input  logic [2*BITS-1:0]         zIn,
    input  logic                      mdrRead,
    input  logic [BITS-1:0]           memDataIn,
    input  logic                      pcInc,
    input  logic                      clearFlags,
    output logic [BITS*REGISTERS-1:0] registerStream,
    output logic                      loadConflict,
    output logic [COUNT_BITS-1:0]     writeCount
);

`ifdef R0_ZERO_EN
    localparam bit R0_HARD = 1'b1;
`else
    localparam bit R0_HARD = 1'b0;
`endif

    logic [BITS-1:0]       pc_q, pc_d;
    logic [BITS-1:0]       zlo_q, zlo_d;
    logic [BITS-1:0]       zhi_q, zhi_d;
    logic [BITS-1:0]       mdr_q, mdr_d;
    logic                  conflict_q, conflict_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic                  conflict_set;
    logic                  any_en;

    always_comb begin
        pc_d = pc_q;
        if (registerLoad[PC_IDX]) pc_d = busMuxIn;
        else if (pcInc)           pc_d = pc_q + 1'b1;

        zlo_d = zlo_q;
        zhi_d = zhi_q;
        if (zLoad) begin
            zlo_d = zIn[BITS-1:0];
            zhi_d = zIn[2*BITS-1:BITS];
        end else begin
            if (registerLoad[ZLO_IDX]) zlo_d = busMuxIn;
            if (registerLoad[ZHI_IDX]) zhi_d = busMuxIn;
        end

        mdr_d = mdr_q;
        if (registerLoad[MDR_IDX]) mdr_d = mdrRead ? memDataIn : busMuxIn;

        // A new conflict outranks a same-cycle clear.
        conflict_set = (zLoad & (registerLoad[ZLO_IDX] | registerLoad[ZHI_IDX]))
                     | (registerLoad[PC_IDX] & pcInc);
        conflict_d = conflict_q;
        if (conflict_set)    conflict_d = 1'b1;
        else if (clearFlags) conflict_d = 1'b0;

        any_en  = (|registerLoad) | zLoad | pcInc;
        count_d = count_q;
        if (any_en && count_q != '1) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            pc_q       <= '0;
            zlo_q      <= '0;
            zhi_q      <= '0;
            mdr_q      <= '0;
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            zlo_q      <= zlo_d;
            zhi_q      <= zhi_d;
            mdr_q      <= mdr_d;
            conflict_q <= conflict_d;
            count_q    <= count_d;
        end
    end

    for (genvar i = 0; i < REGISTERS; i++) begin : g_slot
        if (i == PC_IDX) begin : g_pc
            assign registerStream[i*BITS +: BITS] = pc_q;
        end else if (i == ZLO_IDX) begin : g_zlo
            assign registerStream[i*BITS +: BITS] = zlo_q;
        end else if (i == ZHI_IDX) begin : g_zhi
            assign registerStream[i*BITS +: BITS] = zhi_q;
        end else if (i == MDR_IDX) begin : g_mdr
            assign registerStream[i*BITS +: BITS] = mdr_q;
        end else if (R0_HARD && i == R0_IDX) begin : g_r0
            assign registerStream[i*BITS +: BITS] = '0;
        end else begin : g_gen
            register_stream_writer_load_register #(
                .BITS(BITS)
            ) u_reg (
                .clk  (clk),
                .clr  (clr),
                .load (registerLoad[i]),
                .d    (busMuxIn),
                .q    (registerStream[i*BITS +: BITS])
            );
        end
    end

    assign loadConflict = conflict_q;
    assign writeCount   = count_q;

endmodule

// File: tb/tb_register_stream_writer.sv
// Scoreboard bench for register_stream_writer (COUNT_BITS=4 instance).
// Honours R0_ZERO_EN for the r0 expectation.
module tb_register_stream_writer;

    localparam int B  = 32;
    localparam int R  = 25;
    localparam int CB = 4;
    localparam int K_CONF  = 25;
    localparam int K_COUNT = 26;

    logic             clk;
    logic             clr;
    logic [B-1:0]     busMuxIn;
    logic [R-1:0]     registerLoad;
    logic             zLoad;
    logic [2*B-1:0]   zIn;
    logic             mdrRead;
    logic [B-1:0]     memDataIn;
    logic             pcInc;
    logic             clearFlags;
    logic [B*R-1:0]   registerStream;
    logic             loadConflict;
    logic [CB-1:0]    writeCount;

    register_stream_writer #(
        .BITS(B), .REGISTERS(R), .COUNT_BITS(CB)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .busMuxIn       (busMuxIn),
        .registerLoad   (registerLoad),
        .zLoad          (zLoad),
        .zIn            (zIn),
        .mdrRead        (mdrRead),
        .memDataIn      (memDataIn),
        .pcInc          (pcInc),
        .clearFlags     (clearFlags),
        .registerStream (registerStream),
        .loadConflict   (loadConflict),
        .writeCount     (writeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(input int kind);
        if (kind == K_CONF)  return {31'd0, loadConflict};
        if (kind == K_COUNT) return {28'd0, writeCount};
        return registerStream[kind*B +: B];
    endfunction

    // Monitor: after each edge, compare everything due this cycle.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                exp_t e;
                logic [31:0] act;
                e = q.pop_front();
                act = observe(e.kind);
                n_checks++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = edge_cnt + 1;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle();
        clr          = 1'b1;
        busMuxIn     = '0;
        registerLoad = '0;
        zLoad        = 1'b0;
        zIn          = '0;
        mdrRead      = 1'b0;
        memDataIn    = '0;
        pcInc        = 1'b0;
        clearFlags   = 1'b0;
    endtask

    initial begin
        logic [31:0] r0_exp;
        idle();

        // Reset with every enable asserted
        @(negedge clk);
        idle();
        clr = 1'b0;
        registerLoad = '1;
        zLoad = 1'b1;
        zIn = 64'hFFFF_FFFF_FFFF_FFFF;
        pcInc = 1'b1;
        mdrRead = 1'b1;
        memDataIn = 32'hFFFF_FFFF;
        busMuxIn = 32'hFFFF_FFFF;
        for (int i = 0; i < R; i++) expect_v(i, 32'h0, $sformatf("rst_slot%0d", i));
        expect_v(K_CONF, 32'h0, "rst_conflict");
        expect_v(K_COUNT, 32'h0, "rst_count");

        // Broadcast
        @(negedge clk);
        idle();
        busMuxIn = 32'hA5A5_0001;
        registerLoad[3] = 1'b1;
        registerLoad[17] = 1'b1;
        registerLoad[21] = 1'b1;
        expect_v(3, 32'hA5A5_0001, "bc_r3");
        expect_v(17, 32'hA5A5_0001, "bc_ir");
        expect_v(21, 32'hA5A5_0001, "bc_mar");
        expect_v(4, 32'h0, "bc_r4");
        expect_v(18, 32'h0, "bc_ry");
        expect_v(K_COUNT, 32'd1, "bc_count");

        // Z precedence over bus enable
        @(negedge clk);
        idle();
        zLoad = 1'b1;
        zIn = 64'h1234_5678_9ABC_DEF0;
        registerLoad[19] = 1'b1;
        busMuxIn = 32'hFFFF_FFFF;
        expect_v(19, 32'h9ABC_DEF0, "z_lo");
        expect_v(20, 32'h1234_5678, "z_hi");
        expect_v(K_CONF, 32'h1, "z_conflict");
        expect_v(K_COUNT, 32'd2, "z_count");
        expect_v(3, 32'hA5A5_0001, "z_r3_hold");

        @(negedge clk);
        idle();
        clearFlags = 1'b1;
        expect_v(K_CONF, 32'h0, "clr1_conflict");
        expect_v(K_COUNT, 32'd2, "clr1_count");

        // PC wrap and load priority
        @(negedge clk);
        idle();
        registerLoad[16] = 1'b1;
        busMuxIn = 32'hFFFF_FFFF;
        expect_v(16, 32'hFFFF_FFFF, "pc_load");
        expect_v(K_COUNT, 32'd3, "pc_load_count");

        @(negedge clk);
        idle();
        pcInc = 1'b1;
        expect_v(16, 32'h0, "pc_wrap");
        expect_v(K_CONF, 32'h0, "pc_wrap_conflict");
        expect_v(K_COUNT, 32'd4, "pc_wrap_count");

        @(negedge clk);
        idle();
        registerLoad[16] = 1'b1;
        pcInc = 1'b1;
        busMuxIn = 32'h40;
        expect_v(16, 32'h40, "pc_prio");
        expect_v(K_CONF, 32'h1, "pc_conflict");
        expect_v(K_COUNT, 32'd5, "pc_prio_count");

        // Set beats same-cycle clear
        @(negedge clk);
        idle();
        clearFlags = 1'b1;
        zLoad = 1'b1;
        zIn = 64'h0;
        registerLoad[20] = 1'b1;
        busMuxIn = 32'h777;
        expect_v(K_CONF, 32'h1, "set_wins");
        expect_v(20, 32'h0, "z_hi_zero");
        expect_v(K_COUNT, 32'd6, "set_wins_count");

        @(negedge clk);
        idle();
        clearFlags = 1'b1;
        expect_v(K_CONF, 32'h0, "clr2_conflict");

        // MDR source select
        @(negedge clk);
        idle();
        memDataIn = 32'hDEAD_BEEF;
        busMuxIn = 32'h1;
        mdrRead = 1'b1;
        registerLoad[24] = 1'b1;
        expect_v(24, 32'hDEAD_BEEF, "mdr_mem");
        expect_v(K_COUNT, 32'd7, "mdr_mem_count");

        @(negedge clk);
        idle();
        memDataIn = 32'hDEAD_BEEF;
        busMuxIn = 32'h1;
        registerLoad[24] = 1'b1;
        expect_v(24, 32'h1, "mdr_bus");

        @(negedge clk);
        idle();
        memDataIn = 32'hCAFE_F00D;
        mdrRead = 1'b1;
        expect_v(24, 32'h1, "mdr_hold");
        expect_v(K_COUNT, 32'd8, "mdr_hold_count");

        // Z half from bus when zLoad is low
        @(negedge clk);
        idle();
        registerLoad[19] = 1'b1;
        busMuxIn = 32'h55;
        expect_v(19, 32'h55, "zlo_bus");
        expect_v(20, 32'h0, "zhi_hold");
        expect_v(K_CONF, 32'h0, "zlo_bus_conflict");
        expect_v(K_COUNT, 32'd9, "zlo_bus_count");

        // r0 write
`ifdef R0_ZERO_EN
        r0_exp = 32'h0;
`else
        r0_exp = 32'h7;
`endif
        @(negedge clk);
        idle();
        registerLoad[0] = 1'b1;
        busMuxIn = 32'h7;
        expect_v(0, r0_exp, "r0_write");
        expect_v(K_COUNT, 32'd10, "r0_count");

        // Counter saturation
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            idle();
            registerLoad[5] = 1'b1;
            busMuxIn = 32'h100 + k;
            expect_v(5, 32'h100 + k, $sformatf("sat_r5_%0d", k));
            expect_v(K_COUNT, (11 + k > 15) ? 32'd15 : 32'(11 + k),
                     $sformatf("sat_count_%0d", k));
        end

        // Mid-sequence reset discards loads
        @(negedge clk);
        idle();
        registerLoad[16] = 1'b1;
        pcInc = 1'b1;
        busMuxIn = 32'h99;
        expect_v(16, 32'h99, "pre_rst_pc");
        expect_v(K_CONF, 32'h1, "pre_rst_conflict");

        @(negedge clk);
        idle();
        clr = 1'b0;
        registerLoad[3] = 1'b1;
        registerLoad[16] = 1'b1;
        pcInc = 1'b1;
        busMuxIn = 32'h123;
        expect_v(3, 32'h0, "mid_rst_r3");
        expect_v(16, 32'h0, "mid_rst_pc");
        expect_v(5, 32'h0, "mid_rst_r5");
        expect_v(K_CONF, 32'h0, "mid_rst_conflict");
        expect_v(K_COUNT, 32'h0, "mid_rst_count");

        @(negedge clk);
        idle();
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
